// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-port arbiter (CPU/DMA) in front of a single-port synchronous RAM

module mem_arbiter #(
  parameter int ADDR_WIDTH   = 12,
  parameter int DATA_WIDTH   = 8,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  reset_,
  input  logic                  req0,
  input  logic                  req1,
  input  logic                  we0,
  input  logic                  we1,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [ADDR_WIDTH-1:0] addr1,
  input  logic [DATA_WIDTH-1:0] wdata0,
  input  logic [DATA_WIDTH-1:0] wdata1,
  output logic                  gnt0,
  output logic                  gnt1,
  output logic                  rvalid0,
  output logic                  rvalid1,
  output logic [DATA_WIDTH-1:0] rdata0,
  output logic [DATA_WIDTH-1:0] rdata1,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_din,
  output logic                  ram_we,
  input  logic [DATA_WIDTH-1:0] ram_dout,
  output logic                  busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    READ   = 2'd2
  } state_t;

  localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

  state_t     state;
  logic       win;         // port that owns the access in flight (1 = DMA)
  logic [7:0] starve_cnt;  // CPU grants in a row while the DMA was waiting
  logic       pick1;

  // DMA wins when alone, or when the CPU has starved it for STARVE_LIMIT grants
  always_comb begin
    pick1 = req1 && (!req0 || (starve_cnt == LIMIT));
  end

  // Arbitration FSM; every output is registered here so pulses are glitch-free
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      state      <= IDLE;
      win        <= 1'b0;
      starve_cnt <= 8'd0;
      gnt0       <= 1'b0;
      gnt1       <= 1'b0;
      rvalid0    <= 1'b0;
      rvalid1    <= 1'b0;
      rdata0     <= '0;
      rdata1     <= '0;
      ram_addr   <= '0;
      ram_din    <= '0;
      ram_we     <= 1'b0;
      busy       <= 1'b0;
    end else begin
      gnt0    <= 1'b0;
      gnt1    <= 1'b0;
      rvalid0 <= 1'b0;
      rvalid1 <= 1'b0;
      case (state)
        IDLE: begin
          if (!req1) begin
            starve_cnt <= 8'd0;
          end
          if (req0 || req1) begin
            win      <= pick1;
            gnt0     <= !pick1;
            gnt1     <= pick1;
            ram_addr <= pick1 ? addr1  : addr0;
            ram_din  <= pick1 ? wdata1 : wdata0;
            ram_we   <= pick1 ? we1    : we0;
            // a CPU win while the DMA waits can only happen below LIMIT, so this saturates
            if (pick1) begin
              starve_cnt <= 8'd0;
            end else if (req1 && (starve_cnt != LIMIT)) begin
              starve_cnt <= starve_cnt + 8'd1;
            end
            state <= ACCESS;
            busy  <= 1'b1;
          end
        end
        ACCESS: begin
          // the RAM samples address/data/we at this edge
          ram_we <= 1'b0;
          if (ram_we) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            state <= READ;
          end
        end
        READ: begin
          if (win) begin
            rdata1  <= ram_dout;
            rvalid1 <= 1'b1;
          end else begin
            rdata0  <= ram_dout;
            rvalid0 <= 1'b1;
          end
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state  <= IDLE;
          ram_we <= 1'b0;
          busy   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_WIDTH, default 12: RAM word address width.
REQ-002 Parameter DATA_WIDTH, default 8: RAM data width.
REQ-003 Parameter STARVE_LIMIT, default 4, range 1-255: maximum number of consecutive port-0 grants while port 1 is waiting.
REQ-004 clk  in  1  single clock for all logic; same clock as the synchronous RAM.
REQ-005 reset_  in  1  asynchronous, active-low reset.
REQ-006 req0, req1  in  1 each  access request, port 0 (CPU) and port 1 (DMA).
REQ-007 we0, we1  in  1 each  1 = write, 0 = read.
REQ-008 addr0, addr1  in  ADDR_WIDTH each  word address.
REQ-009 wdata0, wdata1  in  DATA_WIDTH each  write data.
REQ-010 gnt0, gnt1  out  1 each  registered one-cycle pulse; request accepted.
REQ-011 rvalid0, rvalid1  out  1 each  registered one-cycle pulse; rdata is valid.
REQ-012 rdata0, rdata1  out  DATA_WIDTH each  registered read data, held until that port's next read completes.
REQ-013 ram_addr  out  ADDR_WIDTH  registered RAM address.
REQ-014 ram_din  out  DATA_WIDTH  registered RAM write data.
REQ-015 ram_we  out  1  registered RAM write enable.
REQ-016 ram_dout  in  DATA_WIDTH  RAM read data; valid one clk after the address is sampled.
REQ-017 busy  out  1  high whenever the state is not IDLE.

Function
REQ-018 The FSM SHALL have three states: IDLE, ACCESS and READ.
REQ-019 IDLE: at a clk edge with req0 or req1 high, the arbiter SHALL select a winner, register the winner's addr/wdata/we into ram_addr/ram_din/ram_we, set the winner's gnt for one cycle, and go to ACCESS. With neither request high it SHALL stay in IDLE.
REQ-020 ACCESS: the RAM SHALL sample at the next edge. ram_we and gnt SHALL clear at that edge. The next state SHALL be READ for a read and IDLE for a write.
REQ-021 READ: at the next edge the arbiter SHALL load ram_dout into the winner's rdata, pulse that port's rvalid for one cycle, and go to IDLE.
REQ-022 Latency from the sampling edge E0: gnt high during E0-E1; write committed at E1; for a read, rvalid and rdata are valid during E2-E3.
REQ-023 Minimum spacing between grants: write 2 cycles, read 3 cycles.
REQ-024 req, we, addr and wdata SHALL only be sampled in IDLE. They are ignored in ACCESS and READ, and the requester holds them stable until gnt.
REQ-025 req high at any IDLE sampling edge counts as a new request. A requester wanting a single access SHALL drop req in the cycle gnt is high.
REQ-026 Priority: port 0 SHALL win when both requests are high, unless starve_cnt == STARVE_LIMIT, in which case port 1 SHALL win.
REQ-027 starve_cnt (8-bit) SHALL increment on each port-0 grant made while req1 is high. It SHALL clear on any port-1 grant, and on any IDLE edge where req1 is low. It SHALL saturate at STARVE_LIMIT and never wrap.
REQ-028 A single requester SHALL always be granted, regardless of starve_cnt.
REQ-029 At most one gnt and at most one rvalid SHALL be high in any cycle.
REQ-030 rdata0 and rdata1 SHALL be unchanged by writes and by the other port's reads.
REQ-031 ram_addr and ram_din SHALL hold their last values outside ACCESS. ram_we SHALL be high only in ACCESS for a write.

Reset
REQ-032 While reset_ is low, asynchronously:
  - state = IDLE;
  - gnt0/1, rvalid0/1, ram_we and busy = 0;
  - ram_addr, ram_din, rdata0/1 and starve_cnt = 0.
REQ-033 reset_ asserted in ACCESS SHALL drop ram_we immediately, so the pending write does not occur.
REQ-034 reset_ asserted in READ SHALL produce no rvalid.
REQ-035 After reset_ deasserts, the first request SHALL be sampled at the first clk edge.

Verification
REQ-036 Port-0 write 0x5A to 0x010, then port-0 read of 0x010 -> gnt0 at E0; ram_we high for exactly 1 cycle; read returns rdata0 = 0x5A with rvalid0 in cycle E2-E3.
REQ-037 req0 and req1 both high, both reads, same edge -> gnt0 first; gnt1 at the next IDLE edge; rvalid0 and rvalid1 never overlap.
REQ-038 req0 and req1 held high continuously, STARVE_LIMIT = 4 -> grant sequence 0,0,0,0,1,0,0,0,0,1.
REQ-039 Port-1 read of 0x0FF (holds 0xC3) while rdata0 = 0x5A -> rdata1 = 0xC3; rdata0 stays 0x5A.
REQ-040 reset_ pulsed low during ACCESS of a write of 0x77 to 0x020 -> ram_we falls immediately; location 0x020 keeps its prior value; all outputs are zero.
REQ-041 req1 only, with starve_cnt forced to 3 earlier and req1 then low for one IDLE edge -> starve_cnt = 0; gnt1 on the next request.
